// File: rtl/ff_bist_pkg.sv
// Shared types and constants for the flip-flop bank self-test sequencer:
// FSM states, stimulus vectors, expected-Q table and flip-flop indices.
package ff_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_APPLY,
    ST_CHECK,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic j;
    logic k;
    logic s;
    logic r;
    logic d;
  } vec_t;

  localparam int unsigned NUM_VEC = 4;
  localparam logic [1:0]  LAST_VEC = 2'd3;

  localparam int unsigned FF_JK = 0;
  localparam int unsigned FF_SR = 1;
  localparam int unsigned FF_D  = 2;

  localparam vec_t VEC0 = 5'b00000;
  localparam vec_t VEC1 = 5'b01010;
  localparam vec_t VEC2 = 5'b10101;
  localparam vec_t VEC3 = 5'b11111;

  // Expected Q after each vector, bit order {D, SR, JK}; SR on v3 is the held value.
  localparam logic [2:0] EXP_Q0 = 3'b000;
  localparam logic [2:0] EXP_Q1 = 3'b000;
  localparam logic [2:0] EXP_Q2 = 3'b111;
  localparam logic [2:0] EXP_Q3 = 3'b110;

  function automatic vec_t vec_at(input logic [1:0] idx);
    case (idx)
      2'd0:    vec_at = VEC0;
      2'd1:    vec_at = VEC1;
      2'd2:    vec_at = VEC2;
      default: vec_at = VEC3;
    endcase
  endfunction

  function automatic logic [2:0] exp_q_at(input logic [1:0] idx);
    case (idx)
      2'd0:    exp_q_at = EXP_Q0;
      2'd1:    exp_q_at = EXP_Q1;
      2'd2:    exp_q_at = EXP_Q2;
      default: exp_q_at = EXP_Q3;
    endcase
  endfunction

endpackage

// File: rtl/ff_bist_model.sv
// Golden model of the JK/SR/D bank: cleared in CLEAR, advanced on the
// applied vector, and reports expected Q plus which flip-flops are comparable.
module ff_bist_model
  import ff_bist_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       apply,
  input  vec_t       vec,
  input  logic [1:0] vec_idx,
  output logic [2:0] exp_q,
  output logic [2:0] cmp_valid
);

  logic [2:0] model_q, model_d;

  always_comb begin
    model_d = model_q;
    if (clear) begin
      model_d = '0;
    end else if (apply) begin
      case ({vec.j, vec.k})
        2'b01:   model_d[FF_JK] = 1'b0;
        2'b10:   model_d[FF_JK] = 1'b1;
        2'b11:   model_d[FF_JK] = ~model_q[FF_JK];
        default: model_d[FF_JK] = model_q[FF_JK];
      endcase
      // S=R=1 is illegal for an SR latch; the model simply holds.
      case ({vec.s, vec.r})
        2'b01:   model_d[FF_SR] = 1'b0;
        2'b10:   model_d[FF_SR] = 1'b1;
        default: model_d[FF_SR] = model_q[FF_SR];
      endcase
      model_d[FF_D] = vec.d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      model_q <= '0;
    end else begin
      model_q <= model_d;
    end
  end

  always_comb begin
    cmp_valid = '1;
    if (vec_idx == LAST_VEC) begin
      cmp_valid[FF_SR] = 1'b0;
    end
  end

  assign exp_q = model_q;

endmodule

// File: rtl/ff_bist_ctrl.sv
// Self-test sequencer for a JK/SR/D flip-flop bank: CLEAR then four vectors
// per pass, Q checked after each. Optional Qn check: FF_BIST_QN_CHECK_EN.
module ff_bist_ctrl
  import ff_bist_pkg::*;
#(
  parameter int unsigned NUM_PASSES = 1,
  parameter int unsigned ERR_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [2:0]       err_vec,
  output logic             ff_reset,
  output logic             j,
  output logic             k,
  output logic             s,
  output logic             r,
  output logic             d,
  input  logic             q_jk,
  input  logic             q_sr,
  input  logic             q_d,
  input  logic             qn_jk,
  input  logic             qn_sr,
  input  logic             qn_d
);

  localparam int unsigned SUM_W     = ERR_W + 3;
  localparam logic [7:0]  LAST_PASS = 8'(NUM_PASSES - 1);

  state_e           state_q, state_d;
  logic [1:0]       vec_idx_q, vec_idx_d;
  logic [7:0]       pass_cnt_q, pass_cnt_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;
  logic [2:0]       err_vec_q, err_vec_d;
  logic             pass_q, pass_d;
  logic             ff_reset_q, ff_reset_d;
  vec_t             stim_q, stim_d;

  logic [2:0]       exp_q, cmp_valid, q_bus;
  logic [2:0]       miss_q, miss_qn, miss_any;
  logic [2:0]       miss_cnt;
  logic [SUM_W-1:0] err_sum;
  logic [ERR_W-1:0] err_sat;

  ff_bist_model u_model (
    .clk       (clk),
    .reset     (reset),
    .clear     (state_q == ST_CLEAR),
    .apply     (state_q == ST_APPLY),
    .vec       (stim_q),
    .vec_idx   (vec_idx_q),
    .exp_q     (exp_q),
    .cmp_valid (cmp_valid)
  );

  assign q_bus  = {q_d, q_sr, q_jk};
  assign miss_q = (q_bus ^ exp_q) & cmp_valid;

`ifdef FF_BIST_QN_CHECK_EN
  // Qn is checked on every flip-flop, including SR while its Q is masked.
  assign miss_qn = ~({qn_d, qn_sr, qn_jk} ^ q_bus);
`else
  logic unused_qn;
  assign unused_qn = ^{qn_d, qn_sr, qn_jk};
  assign miss_qn   = '0;
`endif

  assign miss_any = miss_q | miss_qn;
  assign miss_cnt = 3'(miss_q[0])  + 3'(miss_q[1])  + 3'(miss_q[2]) +
                    3'(miss_qn[0]) + 3'(miss_qn[1]) + 3'(miss_qn[2]);
  assign err_sum  = SUM_W'(err_count_q) + SUM_W'(miss_cnt);
  assign err_sat  = (|err_sum[SUM_W-1:ERR_W]) ? '1 : err_sum[ERR_W-1:0];

  always_comb begin
    state_d     = state_q;
    vec_idx_d   = vec_idx_q;
    pass_cnt_d  = pass_cnt_q;
    err_count_d = err_count_q;
    err_vec_d   = err_vec_q;
    pass_d      = pass_q;
    stim_d      = stim_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_CLEAR;
          vec_idx_d   = '0;
          pass_cnt_d  = '0;
          err_count_d = '0;
          err_vec_d   = '0;
          pass_d      = 1'b0;
        end
      end
      ST_CLEAR: begin
        state_d   = ST_APPLY;
        vec_idx_d = '0;
      end
      ST_APPLY: begin
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        err_count_d = err_sat;
        err_vec_d   = err_vec_q | miss_any;
        if (vec_idx_q != LAST_VEC) begin
          vec_idx_d = vec_idx_q + 2'd1;
          state_d   = ST_APPLY;
        end else if (pass_cnt_q != LAST_PASS) begin
          pass_cnt_d = pass_cnt_q + 8'd1;
          state_d    = ST_CLEAR;
        end else begin
          state_d = ST_DONE;
          pass_d  = (err_sat == '0);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Stimulus is registered on state entry so the bank sees a full cycle of setup.
    ff_reset_d = (state_d == ST_CLEAR);
    if (state_d == ST_APPLY) begin
      stim_d = vec_at(vec_idx_d);
    end else if (state_d == ST_CLEAR || state_d == ST_DONE) begin
      stim_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      vec_idx_q   <= '0;
      pass_cnt_q  <= '0;
      err_count_q <= '0;
      err_vec_q   <= '0;
      pass_q      <= 1'b0;
      ff_reset_q  <= 1'b1;
      stim_q      <= '0;
    end else begin
      state_q     <= state_d;
      vec_idx_q   <= vec_idx_d;
      pass_cnt_q  <= pass_cnt_d;
      err_count_q <= err_count_d;
      err_vec_q   <= err_vec_d;
      pass_q      <= pass_d;
      ff_reset_q  <= ff_reset_d;
      stim_q      <= stim_d;
    end
  end

  assign busy      = (state_q == ST_CLEAR) || (state_q == ST_APPLY) || (state_q == ST_CHECK);
  assign done      = (state_q == ST_DONE);
  assign pass      = pass_q;
  assign err_count = err_count_q;
  assign err_vec   = err_vec_q;
  assign ff_reset  = ff_reset_q;
  assign j         = stim_q.j;
  assign k         = stim_q.k;
  assign s         = stim_q.s;
  assign r         = stim_q.r;
  assign d         = stim_q.d;

endmodule

// File: tb/tb_ff_bist_ctrl.sv
// Bench for ff_bist_ctrl: faultable flip-flop bank, cycle-count reference
// model of the sequencer, per-cycle output compare and literal spot checks.
module tb_ff_bist_ctrl;

  localparam int NP    = 2;
  localparam int EW    = 3;
  localparam int RUN_T = 9 * NP;
  localparam int DONE_T = RUN_T + 1;
  localparam int MAXE  = (1 << EW) - 1;

  localparam logic [4:0] VECS [4] = '{5'b00000, 5'b01010, 5'b10101, 5'b11111};
  localparam int EXP_JK [4] = '{0, 0, 1, 0};
  localparam int EXP_SR [4] = '{0, 0, 1, 0};
  localparam int EXP_D  [4] = '{0, 0, 1, 1};

`ifdef FF_BIST_QN_CHECK_EN
  localparam int LIT_ERR  [7] = '{0, 4, 2, 0, 4, 7, 7};
  localparam int LIT_VEC  [7] = '{0, 4, 1, 0, 2, 7, 4};
  localparam int LIT_PASS [7] = '{1, 0, 0, 1, 0, 0, 0};
`else
  localparam int LIT_ERR  [7] = '{0, 4, 2, 0, 4, 7, 0};
  localparam int LIT_VEC  [7] = '{0, 4, 1, 0, 2, 7, 0};
  localparam int LIT_PASS [7] = '{1, 0, 0, 1, 0, 0, 1};
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic busy, done, pass, ff_reset, j, k, s, r, d;
  logic [EW-1:0] err_count;
  logic [2:0] err_vec;
  logic q_jk, q_sr, q_d, qn_jk, qn_sr, qn_d;

  int checks = 0;
  int errors = 0;
  int mode = 0;
  logic cmp_en = 1'b0;

  ff_bist_ctrl #(.NUM_PASSES(NP), .ERR_W(EW)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .pass(pass), .err_count(err_count), .err_vec(err_vec), .ff_reset(ff_reset),
    .j(j), .k(k), .s(s), .r(r), .d(d),
    .q_jk(q_jk), .q_sr(q_sr), .q_d(q_d),
    .qn_jk(qn_jk), .qn_sr(qn_sr), .qn_d(qn_d)
  );

  always #5 clk = ~clk;

  // Faultable bank. Modes: 0 good, 1 D stuck-0, 2 JK holds on 11, 3 SR toggles
  // on 11, 4 SR stuck-1, 5 all Q stuck-1, 6 qn_d tied to q_d, 7 random noise.
  logic jk_s = 1'b0, sr_s = 1'b0, d_s = 1'b0;
  logic [2:0] noise_q = '0, noise_n = '0;

  always @(posedge clk) begin
    if (ff_reset) begin
      jk_s <= 1'b0; sr_s <= 1'b0; d_s <= 1'b0;
    end else begin
      case ({j, k})
        2'b01: jk_s <= 1'b0;
        2'b10: jk_s <= 1'b1;
        2'b11: jk_s <= (mode == 2) ? jk_s : ~jk_s;
        default: ;
      endcase
      case ({s, r})
        2'b01: sr_s <= 1'b0;
        2'b10: sr_s <= 1'b1;
        2'b11: sr_s <= (mode == 3) ? ~sr_s : sr_s;
        default: ;
      endcase
      d_s <= d;
    end
    noise_q <= (mode == 7 && $urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
    noise_n <= (mode == 7 && $urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
  end

  assign q_jk  = (mode == 5) ? 1'b1 : (jk_s ^ noise_q[0]);
  assign q_sr  = (mode == 5 || mode == 4) ? 1'b1 : (sr_s ^ noise_q[1]);
  assign q_d   = (mode == 5) ? 1'b1 : (mode == 1) ? 1'b0 : (d_s ^ noise_q[2]);
  assign qn_jk = ~q_jk ^ noise_n[0];
  assign qn_sr = ~q_sr ^ noise_n[1];
  assign qn_d  = (mode == 6) ? q_d : (~q_d ^ noise_n[2]);

  // Reference: ref_t is the cycle number within a run (0 = idle).
  int ref_t = 0;
  int exp_err = 0;
  int exp_vec = 0;
  int exp_pass = 0;
  logic exp_rst = 1'b1;

  int pos, cur_v, cur_n;
  logic [2:0] cur_m;
  logic cur_chk;

  always_comb begin
    pos = 0; cur_v = 0; cur_n = 0; cur_m = '0; cur_chk = 1'b0;
    if (ref_t >= 1 && ref_t <= RUN_T) begin
      pos = (ref_t - 1) % 9;
      if (pos != 0 && pos % 2 == 0) begin
        cur_chk = 1'b1;
        cur_v = pos / 2 - 1;
        if (int'(q_jk) != EXP_JK[cur_v]) begin cur_n++; cur_m[0] = 1'b1; end
        if (cur_v != 3 && int'(q_sr) != EXP_SR[cur_v]) begin cur_n++; cur_m[1] = 1'b1; end
        if (int'(q_d) != EXP_D[cur_v]) begin cur_n++; cur_m[2] = 1'b1; end
`ifdef FF_BIST_QN_CHECK_EN
        if (qn_jk == q_jk) begin cur_n++; cur_m[0] = 1'b1; end
        if (qn_sr == q_sr) begin cur_n++; cur_m[1] = 1'b1; end
        if (qn_d == q_d) begin cur_n++; cur_m[2] = 1'b1; end
`endif
      end
    end
  end

  function automatic int sat_add(input int a, input int b);
    return (a + b > MAXE) ? MAXE : a + b;
  endfunction

  function automatic int exp_stim(input int t);
    int p;
    exp_stim = 0;
    if (t >= 1 && t <= RUN_T) begin
      p = (t - 1) % 9;
      if (p != 0) exp_stim = int'(VECS[(p - 1) / 2]);
    end
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      ref_t <= 0; exp_err <= 0; exp_vec <= 0; exp_pass <= 0; exp_rst <= 1'b1;
    end else begin
      exp_rst <= 1'b0;
      if (ref_t == 0) begin
        if (start) begin
          ref_t <= 1; exp_err <= 0; exp_vec <= 0; exp_pass <= 0;
        end
      end else if (ref_t == DONE_T) begin
        ref_t <= 0;
      end else begin
        ref_t <= ref_t + 1;
        if (cur_chk) begin
          exp_err <= sat_add(exp_err, cur_n);
          exp_vec <= exp_vec | int'(cur_m);
          if (ref_t == RUN_T) exp_pass <= (sat_add(exp_err, cur_n) == 0) ? 1 : 0;
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy", int'(busy), (ref_t >= 1 && ref_t <= RUN_T) ? 1 : 0);
      chk("done", int'(done), (ref_t == DONE_T) ? 1 : 0);
      chk("ff_reset", int'(ff_reset),
          (exp_rst || (ref_t >= 1 && ref_t <= RUN_T && (ref_t - 1) % 9 == 0)) ? 1 : 0);
      chk("stim", int'({j, k, s, r, d}), exp_stim(ref_t));
      chk("err_count", int'(err_count), exp_err);
      chk("err_vec", int'(err_vec), exp_vec);
      chk("pass", int'(pass), exp_pass);
    end
  end

  task automatic run_once(output int cyc);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 1;
    while (!done && cyc < 200) begin
      start = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (!done) begin
      errors++;
      $display("FAIL run_timeout: got no done expected done by cycle %0d", DONE_T);
    end
  endtask

  initial begin
    int cyc;
    int seen;
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    chk("rst_ff_reset", int'(ff_reset), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(err_count), 0);
    reset = 1'b1;
    @(negedge clk);

    for (int m = 0; m < 7; m++) begin
      mode = m;
      run_once(cyc);
      chk("lit_done_cycle", cyc, 19);
      chk("lit_err_count", int'(err_count), LIT_ERR[m]);
      chk("lit_err_vec", int'(err_vec), LIT_VEC[m]);
      chk("lit_pass", int'(pass), LIT_PASS[m]);
      repeat (2) @(negedge clk);
    end

    // Abort at cycle 5, then confirm no done and a clean rerun.
    mode = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_ff_reset", int'(ff_reset), 1);
    chk("abort_busy", int'(busy), 0);
    chk("abort_stim", int'({j, k, s, r, d}), 0);
    reset = 1'b1;
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("abort_no_done", seen, 0);
    run_once(cyc);
    chk("abort_rerun_done_cycle", cyc, 19);
    chk("abort_rerun_pass", int'(pass), 1);

    for (int it = 0; it < 24; it++) begin
      mode = $urandom_range(0, 7);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if ($urandom_range(0, 4) == 0) begin
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat ($urandom_range(0, 16)) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
      end else begin
        run_once(cyc);
        chk("rand_done_cycle", cyc, 19);
      end
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
